// File: rtl/dmem_responder.sv
// Data-memory responder for the memory-stage load/store interface.
// Accepts one byte-enabled read or write at a time, waits WAIT_CYCLES
// cycles, performs the access, then holds the response until it is taken.
module dmem_responder #(
    parameter int DATA_W      = 64,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 512,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [ADDR_W-1:0]     i_req_addr,
    input  logic [DATA_W-1:0]     i_req_wdata,
    input  logic [DATA_W/8-1:0]   i_req_be,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_W-1:0]     o_rsp_rdata,
    output logic                  o_rsp_err
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               err_q, err_d;

    // Request captured at accept time; only consumed when leaving WAIT.
    logic               we_q;
    logic [IDX_W-1:0]   idx_q;
    logic               oor_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [BE_W-1:0]    be_q;

    logic [DATA_W-1:0]  mem [DEPTH];

    logic               req_fire;
    logic [IDX_W-1:0]   req_idx;
    logic               req_oor;
    logic               commit;

    // Operands of the access being committed this cycle.
    logic               c_we;
    logic [IDX_W-1:0]   c_idx;
    logic               c_oor;
    logic [DATA_W-1:0]  c_wdata;
    logic [BE_W-1:0]    c_be;

    // The byte offset within a word carries no information for this memory.
    logic               unused_addr_lsbs;
    assign unused_addr_lsbs = ^i_req_addr[2:0];

    // Handshake signals depend only on state, and are forced low during reset.
    assign o_req_ready = (state_q == S_IDLE) && !rst;
    assign o_rsp_valid = (state_q == S_RESP) && !rst;
    assign o_rsp_rdata = rdata_q;
    assign o_rsp_err   = err_q;

    assign req_fire = i_req_valid && o_req_ready;
    assign req_idx  = i_req_addr[IDX_W+2:3];
    assign req_oor  = |i_req_addr[ADDR_W-1:IDX_W+3];

    // With zero wait states the commit happens straight from IDLE, so the
    // operands come from the request port instead of the capture registers.
    assign c_we    = (state_q == S_IDLE) ? i_req_we    : we_q;
    assign c_idx   = (state_q == S_IDLE) ? req_idx     : idx_q;
    assign c_oor   = (state_q == S_IDLE) ? req_oor     : oor_q;
    assign c_wdata = (state_q == S_IDLE) ? i_req_wdata : wdata_q;
    assign c_be    = (state_q == S_IDLE) ? i_req_be    : be_q;

    // Next-state, wait counter and commit strobe.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_fire) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES);
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end
            end
            S_RESP: begin
                if (i_rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Response payload: sampled once on entry to RESP, then held.
    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (commit) begin
            err_d   = c_oor;
            rdata_d = (!c_we && !c_oor) ? mem[c_idx] : '0;
        end
    end

    // Control state and response registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of block order.
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Request capture on accept.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            we_q    <= i_req_we;
            idx_q   <= req_idx;
            oor_q   <= req_oor;
            wdata_q <= i_req_wdata;
            be_q    <= i_req_be;
        end
    end

    // Byte-lane write into storage; a reset on the commit edge cancels it.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; contents survive rst and
        // are only defined once written.
        if (commit && !rst && c_we && !c_oor) begin
            for (int k = 0; k < BE_W; k++) begin
                if (c_be[k]) begin
                    mem[c_idx][8*k +: 8] <= c_wdata[8*k +: 8];
                end
            end
        end
    end

endmodule
